mdu_ctrl: RTL and testbench

Multiply/divide unit controller for the execute stage. Owns the HI/LO registers. Accepts one MDU operation at a time over a valid/ready handshake and sequences it:
- a 2-stage partial-product multiply (four 16x16 products, combined and sign-fixed), or
- a 32-iteration restoring divider.

Writes HI/LO at completion and pulses out_valid. Supports pipeline flush on exception.

---
 rtl/mdu_ctrl_pkg.sv | 47 ++++
 rtl/mdu_ctrl_if.sv | 39 +++
 rtl/mdu_div_step.sv | 30 +++
 rtl/mdu_ctrl.sv | 246 ++++++++++++++++++++++++
 tb/tb_mdu_ctrl.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mdu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mdu_ctrl_pkg
// Shared types and constants for the multiply/divide unit controller.
//   mdu_op_t    : operation encoding carried on the 4-bit op field
//   mdu_state_t : controller FSM states
//   MDU_WIDTH, MDU_DIV_ITERS : datapath width and divider iteration count
//   mdu_mag()   : magnitude of a 32-bit operand, optionally treated as signed
// Optional feature macro: MDU_MADD_EN (adds the MUL_ACC state).
// ---------------------------------------------------------------------------
package mdu_ctrl_pkg;

    localparam int MDU_WIDTH     = 32;
    localparam int MDU_DIV_ITERS = 32;

    typedef enum logic [3:0] {
        MDU_NOP   = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MTHI  = 4'd5,
        MDU_MTLO  = 4'd6,
        MDU_MADD  = 4'd7,
        MDU_MADDU = 4'd8,
        MDU_MSUB  = 4'd9,
        MDU_MSUBU = 4'd10
    } mdu_op_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_MUL_PP  = 3'd1,
        ST_MUL_SUM = 3'd2,
        ST_DIV_RUN = 3'd3,
        ST_DIV_FIX = 3'd4
`ifdef MDU_MADD_EN
        ,
        ST_MUL_ACC = 3'd5
`endif
    } mdu_state_t;

    // Absolute value when sgn is set, raw value otherwise. The most negative
    // input maps to 0x80000000, which is its correct unsigned magnitude.
    function automatic logic [31:0] mdu_mag(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// ---------------------------------------------------------------------------
// mdu_ctrl_if
// Request/result bundle between the execute stage and the MDU controller.
//   in_valid/in_ready : request handshake, op/a/b qualified by in_valid
//   flush             : abort any in-flight operation
//   busy              : !in_ready
//   out_valid, hi, lo : completion pulse and the HI/LO registers
//   dbg_state         : controller FSM state, for observation only
// Handshake: a request transfers on a rising edge where in_valid && in_ready
// && !flush. The requester holds op/a/b stable with in_valid high until that
// edge; in_valid raised while in_ready is low is simply not taken.
// out_valid is a single-cycle pulse with no back-pressure.
// ---------------------------------------------------------------------------
interface mdu_ctrl_if;
    import mdu_ctrl_pkg::*;

    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        out_valid;
    logic [31:0] hi;
    logic [31:0] lo;
    mdu_state_t  dbg_state;

    modport master (
        output in_valid, op, a, b, flush,
        input  in_ready, busy, out_valid, hi, lo, dbg_state
    );

    modport slave (
        input  in_valid, op, a, b, flush,
        output in_ready, busy, out_valid, hi, lo, dbg_state
    );

endinterface

// File: rtl/mdu_div_step.sv
// ---------------------------------------------------------------------------
// mdu_div_step
// One combinational restoring-division step.
//   rem_i, quo_i, divisor_i : current partial remainder, dividend/quotient
//                             shift register and divisor
//   rem_o, quo_o            : values after shifting {rem,quo} left by one and
//                             conditionally subtracting the divisor
// ---------------------------------------------------------------------------
module mdu_div_step (
    input  logic [31:0] rem_i,
    input  logic [31:0] quo_i,
    input  logic [31:0] divisor_i,
    output logic [31:0] rem_o,
    output logic [31:0] quo_o
);

    logic [32:0] shifted;
    logic [32:0] diff;
    logic        fits;

    // The shifted remainder can reach 33 bits, so compare in 33 bits; no
    // borrow out of the subtraction means the divisor fits.
    assign shifted = {rem_i, quo_i[31]};
    assign diff    = shifted - {1'b0, divisor_i};
    assign fits    = ~diff[32];

    assign rem_o = fits ? diff[31:0] : shifted[31:0];
    assign quo_o = {quo_i[30:0], fits};

endmodule

// File: rtl/mdu_ctrl.sv
// ---------------------------------------------------------------------------
// mdu_ctrl
// Multiply/divide unit controller. Owns HI/LO, accepts one operation at a
// time and sequences either a two-stage 16x16 partial-product multiply or a
// 32-iteration restoring divide. HI/LO are written on the final edge and
// out_valid pulses in the following cycle.
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous, active-high
//   mdu    : mdu_ctrl_if slave (handshake, operands, flush, results, state)
// Parameters: WIDTH (only 32), DIV_ITERS (must equal WIDTH).
// Optional feature macro: MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU through
// an extra MUL_ACC state; without it those ops are accepted as NOPs.
// ---------------------------------------------------------------------------
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int WIDTH     = MDU_WIDTH,
    parameter int DIV_ITERS = MDU_DIV_ITERS
) (
    input  logic        clk,
    input  logic        reset,
    mdu_ctrl_if.slave   mdu
);

    localparam int         HALF     = WIDTH / 2;
    localparam logic [4:0] CNT_LAST = 5'(DIV_ITERS - 1);

    // ---- state -------------------------------------------------------------
    mdu_state_t  state_q, state_d;
    // opa/opb hold operand magnitudes; during a divide opa is the
    // dividend/quotient shift register and opb the divisor.
    logic [31:0] opa_q, opa_d;
    logic [31:0] opb_q, opb_d;
    logic        neg_q, neg_d;     // result (quotient) needs negation
    logic        rneg_q, rneg_d;   // remainder needs negation
    logic [31:0] p0_q, p0_d, p1_q, p1_d, p2_q, p2_d, p3_q, p3_d;
    logic [31:0] rem_q, rem_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
`ifdef MDU_MADD_EN
    logic        acc_q, acc_d;     // accumulate into HI/LO after the product
    logic        sub_q, sub_d;     // subtract rather than add
    logic [63:0] prod_q, prod_d;
`endif

    // ---- decode ------------------------------------------------------------
    mdu_op_t     op_e;
    logic        accept;
    logic        op_mul, op_div, op_signed;
`ifdef MDU_MADD_EN
    logic        op_acc, op_sub;
`endif

    assign op_e   = mdu_op_t'(mdu.op);
    assign accept = mdu.in_valid && (state_q == ST_IDLE) && !mdu.flush;

    // ---- datapath helpers ----------------------------------------------------
    logic [31:0] step_rem, step_quo;
    logic [63:0] mul_sum, mul_result;

    mdu_div_step u_div_step (
        .rem_i     (rem_q),
        .quo_i     (opa_q),
        .divisor_i (opb_q),
        .rem_o     (step_rem),
        .quo_o     (step_quo)
    );

    assign mul_sum = {32'd0, p0_q}
                   + {16'd0, p1_q, 16'd0}
                   + {16'd0, p2_q, 16'd0}
                   + {p3_q, 32'd0};
    assign mul_result = neg_q ? (64'd0 - mul_sum) : mul_sum;

    // ---- next state ----------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        neg_d       = neg_q;
        rneg_d      = rneg_q;
        p0_d        = p0_q;
        p1_d        = p1_q;
        p2_d        = p2_q;
        p3_d        = p3_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        out_valid_d = 1'b0;
        hi_d        = hi_q;
        lo_d        = lo_q;
`ifdef MDU_MADD_EN
        acc_d       = acc_q;
        sub_d       = sub_q;
        prod_d      = prod_q;
        op_acc      = (op_e == MDU_MADD) || (op_e == MDU_MADDU) ||
                      (op_e == MDU_MSUB) || (op_e == MDU_MSUBU);
        op_sub      = (op_e == MDU_MSUB) || (op_e == MDU_MSUBU);
`endif
        op_mul      = (op_e == MDU_MULT) || (op_e == MDU_MULTU);
        op_div      = (op_e == MDU_DIV)  || (op_e == MDU_DIVU);
        op_signed   = (op_e == MDU_MULT) || (op_e == MDU_DIV);
`ifdef MDU_MADD_EN
        op_mul      = op_mul || op_acc;
        op_signed   = op_signed || (op_e == MDU_MADD) || (op_e == MDU_MSUB);
`endif

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (op_e == MDU_MTHI) begin
                        hi_d = mdu.a;
                    end else if (op_e == MDU_MTLO) begin
                        lo_d = mdu.a;
                    end else if (op_mul || op_div) begin
                        opa_d  = mdu_mag(mdu.a, op_signed);
                        opb_d  = mdu_mag(mdu.b, op_signed);
                        neg_d  = op_signed && (mdu.a[31] ^ mdu.b[31]);
                        rneg_d = op_signed && mdu.a[31];
                        rem_d  = 32'd0;
                        cnt_d  = 5'd0;
                        state_d = op_div ? ST_DIV_RUN : ST_MUL_PP;
`ifdef MDU_MADD_EN
                        acc_d  = op_acc;
                        sub_d  = op_sub;
`endif
                    end
                end
            end

            ST_MUL_PP: begin
                p0_d    = opa_q[HALF-1:0]     * opb_q[HALF-1:0];
                p1_d    = opa_q[WIDTH-1:HALF] * opb_q[HALF-1:0];
                p2_d    = opa_q[HALF-1:0]     * opb_q[WIDTH-1:HALF];
                p3_d    = opa_q[WIDTH-1:HALF] * opb_q[WIDTH-1:HALF];
                state_d = ST_MUL_SUM;
            end

            ST_MUL_SUM: begin
`ifdef MDU_MADD_EN
                if (acc_q) begin
                    prod_d  = mul_result;
                    state_d = ST_MUL_ACC;
                end else
`endif
                begin
                    {hi_d, lo_d} = mul_result;
                    out_valid_d  = 1'b1;
                    state_d      = ST_IDLE;
                end
            end

`ifdef MDU_MADD_EN
            ST_MUL_ACC: begin
                {hi_d, lo_d} = sub_q ? ({hi_q, lo_q} - prod_q) : ({hi_q, lo_q} + prod_q);
                out_valid_d  = 1'b1;
                state_d      = ST_IDLE;
            end
`endif

            ST_DIV_RUN: begin
                rem_d = step_rem;
                opa_d = step_quo;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DIV_FIX;
                end
            end

            ST_DIV_FIX: begin
                lo_d        = neg_q  ? (32'd0 - opa_q) : opa_q;
                hi_d        = rneg_q ? (32'd0 - rem_q) : rem_q;
                out_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Flush overrides everything in flight, including the writing edge.
        if (mdu.flush && (state_q != ST_IDLE)) begin
            state_d     = ST_IDLE;
            hi_d        = hi_q;
            lo_d        = lo_q;
            out_valid_d = 1'b0;
        end
    end

    // ---- registers -----------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            opa_q       <= 32'd0;
            opb_q       <= 32'd0;
            neg_q       <= 1'b0;
            rneg_q      <= 1'b0;
            p0_q        <= 32'd0;
            p1_q        <= 32'd0;
            p2_q        <= 32'd0;
            p3_q        <= 32'd0;
            rem_q       <= 32'd0;
            cnt_q       <= 5'd0;
            out_valid_q <= 1'b0;
            hi_q        <= 32'd0;
            lo_q        <= 32'd0;
`ifdef MDU_MADD_EN
            acc_q       <= 1'b0;
            sub_q       <= 1'b0;
            prod_q      <= 64'd0;
`endif
        end else begin
            state_q     <= state_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            neg_q       <= neg_d;
            rneg_q      <= rneg_d;
            p0_q        <= p0_d;
            p1_q        <= p1_d;
            p2_q        <= p2_d;
            p3_q        <= p3_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
`ifdef MDU_MADD_EN
            acc_q       <= acc_d;
            sub_q       <= sub_d;
            prod_q      <= prod_d;
`endif
        end
    end

    // ---- outputs -------------------------------------------------------------
    assign mdu.in_ready  = (state_q == ST_IDLE);
    assign mdu.busy      = (state_q != ST_IDLE);
    assign mdu.out_valid = out_valid_q;
    assign mdu.hi        = hi_q;
    assign mdu.lo        = lo_q;
    assign mdu.dbg_state = state_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mdu_ctrl
// Self-checking bench for mdu_ctrl. Expected {hi,lo} values come from a
// behavioural model (native 64-bit multiply, native divide with the MIPS
// corner cases) and are queued at request time; a monitor pops and compares
// them on every out_valid pulse. Build with +define+MDU_MADD_EN to cover the
// multiply-accumulate ops.
// ---------------------------------------------------------------------------
module tb_mdu_ctrl;
    import mdu_ctrl_pkg::*;

    logic clk;
    logic reset;

    mdu_ctrl_if mif ();

    mdu_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .mdu   (mif)
    );

    // ---- clock / reset -------------------------------------------------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #800000;
        $display("FAIL global_timeout: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    // ---- scoreboard ----------------------------------------------------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] exp_q[$];
    logic [31:0] hi_m, lo_m;
    logic [63:0] mon_e;

    always @(negedge clk) begin
        if (mif.out_valid === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_out_valid: got hi=%h lo=%h, expected no completion",
                         mif.hi, mif.lo);
            end else begin
                mon_e = exp_q.pop_front();
                if ({mif.hi, mif.lo} !== mon_e) begin
                    n_fail++;
                    $display("FAIL result: got hi=%h lo=%h, expected hi=%h lo=%h",
                             mif.hi, mif.lo, mon_e[63:32], mon_e[31:0]);
                end
            end
        end
    end

    // ---- reference model -----------------------------------------------------
    function automatic logic completes(input logic [3:0] op);
`ifdef MDU_MADD_EN
        return (op >= 4'd1 && op <= 4'd4) || (op >= 4'd7 && op <= 4'd10);
`else
        return (op >= 4'd1 && op <= 4'd4);
`endif
    endfunction

    function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] hilo);
        logic signed [63:0] sa, sb;
        logic [63:0] p;
        int          ia, ib;
        logic [31:0] q, r;
        sa = $signed({{32{a[31]}}, a});
        sb = $signed({{32{b[31]}}, b});
        ia = a;
        ib = b;
        p  = 64'd0;
        q  = 32'd0;
        r  = 32'd0;
        case (op)
            4'd1, 4'd7, 4'd9:  p = sa * sb;
            4'd2, 4'd8, 4'd10: p = {32'd0, a} * {32'd0, b};
            4'd3: begin
                if (b == 32'd0) begin
                    q = a[31] ? 32'd1 : 32'hFFFF_FFFF;
                    r = a;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    q = 32'h8000_0000;
                    r = 32'd0;
                end else begin
                    q = ia / ib;
                    r = ia % ib;
                end
            end
            4'd4: begin
                if (b == 32'd0) begin
                    q = 32'hFFFF_FFFF;
                    r = a;
                end else begin
                    q = a / b;
                    r = a % b;
                end
            end
            default: ;
        endcase
        case (op)
            4'd1, 4'd2:  return p;
            4'd3, 4'd4:  return {r, q};
            4'd7, 4'd8:  return hilo + p;
            4'd9, 4'd10: return hilo - p;
            default:     return hilo;
        endcase
    endfunction

    // ---- driver tasks --------------------------------------------------------
    task automatic expect_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] r;
        if (op == MDU_MTHI) begin
            hi_m = a;
        end else if (op == MDU_MTLO) begin
            lo_m = a;
        end else if (completes(op)) begin
            r = model(op, a, b, {hi_m, lo_m});
            exp_q.push_back(r);
            {hi_m, lo_m} = r;
        end
    endtask

    // Drive one request for a single edge; returns #1 after that edge.
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        mif.in_valid = 1'b1;
        mif.op       = op;
        mif.a        = a;
        mif.b        = b;
        @(posedge clk);
        #1;
        mif.in_valid = 1'b0;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        expect_op(op, a, b);
        do_op(op, a, b);
    endtask

    // Called in cycle 1; waits for out_valid and checks its cycle number.
    task automatic wait_done(input int exp_cyc, input string name);
        int cyc;
        cyc = 1;
        while (mif.out_valid !== 1'b1 && cyc < 80) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        n_checks++;
        if (cyc != exp_cyc) begin
            n_fail++;
            $display("FAIL %s_latency: out_valid in cycle %0d, expected cycle %0d", name, cyc, exp_cyc);
        end
        n_checks++;
        if (mif.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_ready_at_done: in_ready=%b, expected 1", name, mif.in_ready);
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_hilo(input string name);
        n_checks++;
        if (mif.hi !== hi_m || mif.lo !== lo_m) begin
            n_fail++;
            $display("FAIL %s: got hi=%h lo=%h, expected hi=%h lo=%h", name, mif.hi, mif.lo, hi_m, lo_m);
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        idle_cycles(2);
        reset = 1'b0;
        hi_m  = 32'd0;
        lo_m  = 32'd0;
    endtask

    // ---- tests ---------------------------------------------------------------
    task automatic test_reset();
        apply_reset();
        n_checks++;
        if (mif.hi !== 32'd0 || mif.lo !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_hilo: got hi=%h lo=%h, expected 0 0", mif.hi, mif.lo);
        end
        n_checks++;
        if (mif.in_ready !== 1'b1 || mif.busy !== 1'b0 || mif.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got ready=%b busy=%b ov=%b, expected 1 0 0",
                     mif.in_ready, mif.busy, mif.out_valid);
        end
        n_checks++;
        if (mif.dbg_state !== ST_IDLE) begin
            n_fail++;
            $display("FAIL reset_state: got %0d, expected %0d", mif.dbg_state, ST_IDLE);
        end
        // Reset in the middle of a multiply clears HI/LO and aborts it.
        do_op(MDU_MTHI, 32'hAAAA_5555, 32'd0);
        do_op(MDU_MULTU, 32'd7, 32'd9);
        reset = 1'b1;
        idle_cycles(1);
        reset = 1'b0;
        hi_m = 32'd0;
        lo_m = 32'd0;
        check_hilo("reset_mid_op_hilo");
        n_checks++;
        if (mif.in_ready !== 1'b1 || mif.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_op_ctrl: got ready=%b ov=%b, expected 1 0", mif.in_ready, mif.out_valid);
        end
        idle_cycles(4);
    endtask

    task automatic test_mult();
        issue(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(3, "multu_max");
        issue(MDU_MULT, 32'hFFFF_FFFE, 32'd3);
        wait_done(3, "mult_neg");
        issue(MDU_MULT, 32'h8000_0000, 32'h8000_0000);
        wait_done(3, "mult_minmin");
        for (int i = 0; i < 4; i++) begin
            issue((i % 2 == 0) ? MDU_MULT : MDU_MULTU, $urandom, $urandom);
            wait_done(3, "mult_rand");
        end
    endtask

    task automatic test_div();
        issue(MDU_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done(34, "div_neg");
        issue(MDU_DIVU, 32'd100, 32'd7);
        wait_done(34, "divu_small");
        issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(34, "div_ovf");
        issue(MDU_DIV, 32'hFFFF_FF00, 32'd0);
        wait_done(34, "div_zero_neg");
        for (int i = 0; i < 3; i++) begin
            issue((i % 2 == 0) ? MDU_DIV : MDU_DIVU, $urandom, $urandom_range(1, 1000));
            wait_done(34, "div_rand");
        end
    endtask

    task automatic test_div_zero_hold();
        int cyc;
        issue(MDU_DIVU, 32'd5, 32'd0);
        // Hold a second request while busy; it may only go in at completion.
        mif.in_valid = 1'b1;
        mif.op       = MDU_DIVU;
        mif.a        = 32'd100;
        mif.b        = 32'd7;
        cyc = 1;
        while (mif.in_ready !== 1'b1 && cyc < 80) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        n_checks++;
        if (cyc != 34 || mif.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_accept_cycle: ready in cycle %0d ov=%b, expected cycle 34 ov=1",
                     cyc, mif.out_valid);
        end
        expect_op(MDU_DIVU, 32'd100, 32'd7);
        @(posedge clk);
        #1;
        mif.in_valid = 1'b0;
        wait_done(34, "hold_second");
    endtask

    task automatic test_flush();
        issue(MDU_MTHI, 32'h0000_1234, 32'd0);
        check_hilo("mthi_write");
        // MULT flushed in MUL_SUM (cycle 2).
        do_op(MDU_MULT, 32'd3, 32'd4);
        idle_cycles(1);
        mif.flush = 1'b1;
        idle_cycles(1);
        mif.flush = 1'b0;
        check_hilo("flush_mult_hilo");
        n_checks++;
        if (mif.in_ready !== 1'b1 || mif.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_mult_ctrl: got ready=%b ov=%b, expected 1 0", mif.in_ready, mif.out_valid);
        end
        // DIV flushed on its writing cycle (DIV_FIX, cycle 33).
        do_op(MDU_DIV, 32'd100, 32'd7);
        idle_cycles(32);
        n_checks++;
        if (mif.dbg_state !== ST_DIV_FIX) begin
            n_fail++;
            $display("FAIL flush_div_state: got %0d, expected %0d", mif.dbg_state, ST_DIV_FIX);
        end
        mif.flush = 1'b1;
        idle_cycles(1);
        mif.flush = 1'b0;
        idle_cycles(3);
        check_hilo("flush_div_fix_hilo");
        // Flush in IDLE blocks MTLO and MULTU.
        mif.flush = 1'b1;
        do_op(MDU_MTLO, 32'hDEAD_BEEF, 32'd0);
        do_op(MDU_MULTU, 32'd5, 32'd5);
        n_checks++;
        if (mif.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_idle_accept: in_ready=%b, expected 1", mif.in_ready);
        end
        mif.flush = 1'b0;
        idle_cycles(4);
        check_hilo("flush_idle_hilo");
    endtask

    task automatic test_back_to_back();
        logic [3:0] op;
        for (int i = 0; i < 8; i++) begin
            op = 4'($urandom_range(1, 4));
            issue(op, $urandom, (i % 3 == 0) ? 32'($urandom_range(0, 15)) : $urandom);
            wait_done((op <= 4'd2) ? 3 : 34, "b2b");
        end
    endtask

    task automatic test_madd();
`ifdef MDU_MADD_EN
        issue(MDU_MTHI, 32'd0, 32'd0);
        issue(MDU_MTLO, 32'hFFFF_FFFF, 32'd0);
        issue(MDU_MADDU, 32'd1, 32'd1);
        wait_done(4, "maddu_carry");
        issue(MDU_MADD, 32'hFFFF_FFFD, 32'd5);
        wait_done(4, "madd_neg");
        issue(MDU_MSUB, $urandom, $urandom);
        wait_done(4, "msub_rand");
        issue(MDU_MSUBU, $urandom, $urandom);
        wait_done(4, "msubu_rand");
        // Flush in MUL_ACC (cycle 3) suppresses the accumulate.
        do_op(MDU_MADDU, 32'd9, 32'd9);
        idle_cycles(2);
        mif.flush = 1'b1;
        idle_cycles(1);
        mif.flush = 1'b0;
        idle_cycles(3);
        check_hilo("flush_macc_hilo");
`else
        issue(MDU_MTLO, 32'h0BAD_F00D, 32'd0);
        issue(MDU_MADD, 32'd5, 32'd6);
        n_checks++;
        if (mif.in_ready !== 1'b1 || mif.dbg_state !== ST_IDLE) begin
            n_fail++;
            $display("FAIL madd_disabled_ctrl: got ready=%b state=%0d, expected 1 0",
                     mif.in_ready, mif.dbg_state);
        end
        issue(MDU_MSUBU, 32'd5, 32'd6);
        idle_cycles(5);
        check_hilo("madd_disabled_hilo");
`endif
        // Unassigned encodings and NOP leave everything alone.
        issue(4'd12, 32'h1111_1111, 32'h2222_2222);
        issue(MDU_NOP, 32'h3333_3333, 32'h4444_4444);
        idle_cycles(5);
        check_hilo("nop_hilo");
    endtask

    // ---- main sequence -------------------------------------------------------
    initial begin
        reset        = 1'b1;
        mif.in_valid = 1'b0;
        mif.op       = 4'd0;
        mif.a        = 32'd0;
        mif.b        = 32'd0;
        mif.flush    = 1'b0;
        hi_m         = 32'd0;
        lo_m         = 32'd0;
        @(posedge clk);
        #1;
        test_reset();
        test_mult();
        test_div();
        test_div_zero_hold();
        test_flush();
        test_back_to_back();
        test_madd();
        idle_cycles(5);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
        end
        check_hilo("final_hilo");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
